// File: rtl/ddr_wr_burst_sched.sv
// Write-side burst scheduler: drains a show-ahead FIFO into fixed-length AXI INCR write bursts
// over a linear frame buffer, one burst outstanding at a time.
module ddr_wr_burst_sched #(
    parameter int                DATA_W      = 64,
    parameter int                ADDR_W      = 28,
    parameter int                BURST_LEN   = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                FRAME_BEATS = 230400
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              frame_start,
    input  logic              fifo_rd_vld,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              fifo_rd_en,
    output logic [ADDR_W-1:0] m_awaddr,
    output logic [7:0]        m_awlen,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [DATA_W-1:0] m_wdata,
    output logic              m_wlast,
    output logic              m_wvalid,
    input  logic              m_wready,
    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready,
    output logic              busy,
    output logic              frame_done,
    output logic              err
);

    localparam int                FCNT_W      = $clog2(FRAME_BEATS + 1);
    localparam logic [7:0]        LAST_BEAT   = 8'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * DATA_W / 8);
    localparam logic [FCNT_W-1:0] FCNT_STEP   = FCNT_W'(BURST_LEN);
    localparam logic [FCNT_W-1:0] FCNT_LAST   = FCNT_W'(FRAME_BEATS - BURST_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_B
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        beat_cnt;
    logic [FCNT_W-1:0] frame_cnt;
    logic              frame_pend;

    assign m_awaddr   = addr;
    assign m_awlen    = LAST_BEAT;
    assign busy       = (state != S_IDLE);
    assign fifo_rd_en = m_wvalid & m_wready;

    // Channel outputs are gated by state so nothing leaks onto the bus outside its phase.
    always_comb begin
        state_nxt = state;
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_wlast   = 1'b0;
        m_wdata   = '0;
        m_bready  = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable && fifo_rd_vld) state_nxt = S_AW;
            end
            S_AW: begin
                m_awvalid = 1'b1;
                if (m_awready) state_nxt = S_W;
            end
            S_W: begin
                m_wvalid = fifo_rd_vld;
                m_wdata  = fifo_rd_data;
                m_wlast  = (beat_cnt == LAST_BEAT);
                if (fifo_rd_vld && m_wready && m_wlast) state_nxt = S_B;
            end
            S_B: begin
                m_bready = 1'b1;
                if (m_bvalid) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            addr       <= BASE_ADDR;
            beat_cnt   <= '0;
            frame_cnt  <= '0;
            frame_pend <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_done <= 1'b0;
            // A frame restart requested mid-burst is deferred until the burst has retired.
            if (state != S_IDLE && frame_start) frame_pend <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (frame_pend || frame_start) begin
                        addr       <= BASE_ADDR;
                        frame_cnt  <= '0;
                        frame_pend <= 1'b0;
                    end
                end
                S_AW: begin
                    if (m_awready) beat_cnt <= '0;
                end
                S_W: begin
                    if (fifo_rd_en) beat_cnt <= beat_cnt + 8'd1;
                end
                S_B: begin
                    if (m_bvalid) begin
                        err <= err | (m_bresp != 2'b00);
                        if (frame_cnt == FCNT_LAST) begin
                            frame_done <= 1'b1;
                            addr       <= BASE_ADDR;
                            frame_cnt  <= '0;
                        end else begin
                            addr      <= addr + BURST_BYTES;
                            frame_cnt <= frame_cnt + FCNT_STEP;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_wr_burst_sched.sv
// Randomized bench for ddr_wr_burst_sched: a queue-based FIFO and AXI slave drive the DUT,
// handshakes are logged and each scenario compares the logs against frame/burst arithmetic.
module tb_ddr_wr_burst_sched;

    localparam int                DATA_W      = 64;
    localparam int                ADDR_W      = 28;
    localparam int                BURST_LEN   = 16;
    localparam int                FRAME_BEATS = 64;
    localparam logic [ADDR_W-1:0] BASE_ADDR   = 28'h0001000;
    localparam int                BURST_BYTES = BURST_LEN * DATA_W / 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic              frame_start = 1'b0;
    logic              fifo_rd_vld = 1'b0;
    logic [DATA_W-1:0] fifo_rd_data = '0;
    logic              fifo_rd_en;
    logic [ADDR_W-1:0] m_awaddr;
    logic [7:0]        m_awlen;
    logic              m_awvalid;
    logic              m_awready = 1'b0;
    logic [DATA_W-1:0] m_wdata;
    logic              m_wlast;
    logic              m_wvalid;
    logic              m_wready = 1'b0;
    logic [1:0]        m_bresp = 2'b00;
    logic              m_bvalid = 1'b0;
    logic              m_bready;
    logic              busy;
    logic              frame_done;
    logic              err;

    always #5 clk = ~clk;

    ddr_wr_burst_sched #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN),
        .BASE_ADDR(BASE_ADDR), .FRAME_BEATS(FRAME_BEATS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .frame_start(frame_start),
        .fifo_rd_vld(fifo_rd_vld), .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
        .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .busy(busy), .frame_done(frame_done), .err(err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [DATA_W-1:0] fifo_q[$];
    logic [DATA_W-1:0] exp_words[$];
    logic [ADDR_W-1:0] aw_log[$];
    logic [DATA_W-1:0] beat_data_log[$];
    logic              beat_last_log[$];
    int                retire_cycle_log[$];
    int                fd_cycle_log[$];

    int written, retired, rd_en_count, viol, cycle, aw_wait, aw_stall_total, first_err_retired;
    int aw_hold, bad_burst;
    bit rand_ready, fs_req, rst_req, err_dropped, prev_err, prev_aw_stall, prev_w_stall;
    logic [ADDR_W-1:0] prev_awaddr;
    logic [DATA_W-1:0] prev_wdata;
    logic              prev_wlast;

    // Expected start address of the k-th burst of a frame.
    function automatic logic [ADDR_W-1:0] exp_addr(int k);
        return BASE_ADDR + ADDR_W'(k * BURST_BYTES);
    endfunction

    function automatic int data_mismatches();
        int m = 0;
        for (int i = 0; i < beat_data_log.size(); i++)
            if (i >= exp_words.size() || beat_data_log[i] !== exp_words[i]) m++;
        return m;
    endfunction

    function automatic int wlast_mismatches();
        int m = 0;
        for (int i = 0; i < beat_last_log.size(); i++)
            if (beat_last_log[i] !== ((i % BURST_LEN) == BURST_LEN - 1)) m++;
        return m;
    endfunction

    // One clock: drive FIFO/slave at negedge, then observe handshakes and invariants.
    task automatic step();
        @(negedge clk);
        rst_n        = !rst_req;
        frame_start  = fs_req;
        fs_req       = 1'b0;
        fifo_rd_vld  = (fifo_q.size() != 0);
        fifo_rd_data = fifo_rd_vld ? fifo_q[0] : '0;
        if (aw_hold > 0) m_awready = (aw_wait >= aw_hold);
        else m_awready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
        m_wready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        m_bvalid = (written > retired) && (rand_ready ? ($urandom_range(0, 2) == 0) : 1'b1);
        m_bresp  = (m_bvalid && retired == bad_burst) ? 2'b10 : 2'b00;
        #1;
        cycle++;
        if (prev_aw_stall && (!m_awvalid || m_awaddr !== prev_awaddr)) viol++;
        if (prev_w_stall && (!m_wvalid || m_wdata !== prev_wdata || m_wlast !== prev_wlast)) viol++;
        if (fifo_rd_en !== (m_wvalid && m_wready)) viol++;
        if (m_wvalid && fifo_q.size() == 0) viol++;
        if (m_awvalid && m_awlen !== 8'(BURST_LEN - 1)) viol++;
        prev_aw_stall = m_awvalid && !m_awready;
        prev_w_stall  = m_wvalid && !m_wready;
        prev_awaddr   = m_awaddr;
        prev_wdata    = m_wdata;
        prev_wlast    = m_wlast;
        if (m_awvalid && !m_awready) begin
            aw_wait++;
            aw_stall_total++;
        end
        if (m_awvalid && m_awready) begin
            aw_log.push_back(m_awaddr);
            aw_wait = 0;
        end
        if (m_wvalid && m_wready) begin
            beat_data_log.push_back(m_wdata);
            beat_last_log.push_back(m_wlast);
            if (m_wlast) written++;
        end
        if (fifo_rd_en) begin
            rd_en_count++;
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
        end
        if (m_bvalid && m_bready) begin
            retired++;
            retire_cycle_log.push_back(cycle);
        end
        if (frame_done) fd_cycle_log.push_back(cycle);
        if (err && first_err_retired < 0) first_err_retired = retired;
        if (prev_err && !err) err_dropped = 1'b1;
        prev_err = err;
    endtask

    task automatic clear_model();
        exp_words = fifo_q;
        aw_log.delete();
        beat_data_log.delete();
        beat_last_log.delete();
        retire_cycle_log.delete();
        fd_cycle_log.delete();
        written = 0; retired = 0; rd_en_count = 0; viol = 0;
        aw_wait = 0; aw_stall_total = 0; first_err_retired = -1;
        err_dropped = 1'b0; prev_err = 1'b0; prev_aw_stall = 1'b0; prev_w_stall = 1'b0;
    endtask

    task automatic do_reset();
        rst_req = 1'b1; enable = 1'b0; rand_ready = 1'b0; aw_hold = 0; bad_burst = -1;
        repeat (3) step();
        fifo_q.delete();
        clear_model();
        rst_req = 1'b0;
    endtask

    task automatic push_words(int n);
        logic [DATA_W-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = {$urandom, $urandom};
            fifo_q.push_back(w);
            exp_words.push_back(w);
        end
    endtask

    task automatic wait_retired(int target, int budget, output bit timed_out);
        int n = 0;
        while (retired < target && n < budget) begin
            step();
            n++;
        end
        timed_out = (retired < target);
    endtask

    task automatic wait_beats(int target, int budget, output bit timed_out);
        int n = 0;
        while (beat_data_log.size() < target && n < budget) begin
            step();
            n++;
        end
        timed_out = (beat_data_log.size() < target);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if ({m_awvalid, m_wvalid, m_wlast, m_bready, fifo_rd_en, busy, frame_done, err} !== 8'h00)
            $display("[TB] FAIL reset_ctrl: got %b required 00000000", {m_awvalid, m_wvalid, m_wlast, m_bready, fifo_rd_en, busy, frame_done, err}); else n_pass++;
        n_checks++; if (m_awaddr !== BASE_ADDR) $display("[TB] FAIL reset_awaddr: got %h required %h", m_awaddr, BASE_ADDR); else n_pass++;
        n_checks++; if (m_awlen !== 8'(BURST_LEN - 1)) $display("[TB] FAIL reset_awlen: got %0d required %0d", m_awlen, BURST_LEN - 1); else n_pass++;
        n_checks++; if (m_wdata !== '0) $display("[TB] FAIL reset_wdata: got %h required 0", m_wdata); else n_pass++;
    endtask

    task automatic test_two_bursts();
        bit to;
        do_reset();
        push_words(32);
        enable = 1'b1;
        wait_retired(2, 400, to);
        repeat (5) step();
        n_checks++; if (to) $display("[TB] FAIL t1_timeout: got %0d retired required 2", retired); else n_pass++;
        n_checks++; if (aw_log.size() !== 2) $display("[TB] FAIL t1_aw_count: got %0d required 2", aw_log.size()); else n_pass++;
        n_checks++; if (aw_log[0] !== exp_addr(0)) $display("[TB] FAIL t1_awaddr0: got %h required %h", aw_log[0], exp_addr(0)); else n_pass++;
        n_checks++; if (aw_log[1] !== exp_addr(1)) $display("[TB] FAIL t1_awaddr1: got %h required %h", aw_log[1], exp_addr(1)); else n_pass++;
        n_checks++; if (rd_en_count !== 32) $display("[TB] FAIL t1_pops: got %0d required 32", rd_en_count); else n_pass++;
        n_checks++; if (beat_data_log.size() !== 32) $display("[TB] FAIL t1_beats: got %0d required 32", beat_data_log.size()); else n_pass++;
        n_checks++; if (data_mismatches() !== 0) $display("[TB] FAIL t1_wdata: got %0d bad beats required 0", data_mismatches()); else n_pass++;
        n_checks++; if (wlast_mismatches() !== 0) $display("[TB] FAIL t1_wlast: got %0d bad beats required 0", wlast_mismatches()); else n_pass++;
        n_checks++; if (viol !== 0) $display("[TB] FAIL t1_protocol: got %0d violations required 0", viol); else n_pass++;
        n_checks++; if (fd_cycle_log.size() !== 0) $display("[TB] FAIL t1_frame_done: got %0d pulses required 0", fd_cycle_log.size()); else n_pass++;
    endtask

    task automatic test_fifo_gap();
        bit to;
        do_reset();
        push_words(6);
        enable = 1'b1;
        wait_beats(6, 200, to);
        repeat (10) step();
        n_checks++; if (beat_data_log.size() !== 6) $display("[TB] FAIL t2_gap_beats: got %0d required 6", beat_data_log.size()); else n_pass++;
        n_checks++; if (rd_en_count !== 6) $display("[TB] FAIL t2_gap_pops: got %0d required 6", rd_en_count); else n_pass++;
        push_words(10);
        wait_retired(1, 200, to);
        n_checks++; if (to) $display("[TB] FAIL t2_timeout: got %0d retired required 1", retired); else n_pass++;
        n_checks++; if (beat_data_log.size() !== 16) $display("[TB] FAIL t2_beats: got %0d required 16", beat_data_log.size()); else n_pass++;
        n_checks++; if (data_mismatches() !== 0) $display("[TB] FAIL t2_wdata: got %0d bad beats required 0", data_mismatches()); else n_pass++;
        n_checks++; if (wlast_mismatches() !== 0) $display("[TB] FAIL t2_wlast: got %0d bad beats required 0", wlast_mismatches()); else n_pass++;
        n_checks++; if (viol !== 0) $display("[TB] FAIL t2_protocol: got %0d violations required 0", viol); else n_pass++;
    endtask

    task automatic test_frame_wrap();
        bit to;
        int bursts = FRAME_BEATS / BURST_LEN + 1;
        do_reset();
        push_words(bursts * BURST_LEN);
        enable = 1'b1;
        wait_retired(bursts, 1000, to);
        repeat (3) step();
        n_checks++; if (to) $display("[TB] FAIL t3_timeout: got %0d retired required %0d", retired, bursts); else n_pass++;
        for (int k = 0; k < bursts; k++) begin
            n_checks++; if (aw_log[k] !== exp_addr(k % (FRAME_BEATS / BURST_LEN)))
                $display("[TB] FAIL t3_awaddr%0d: got %h required %h", k, aw_log[k], exp_addr(k % (FRAME_BEATS / BURST_LEN))); else n_pass++;
        end
        n_checks++; if (fd_cycle_log.size() !== 1) $display("[TB] FAIL t3_fd_count: got %0d required 1", fd_cycle_log.size()); else n_pass++;
        n_checks++; if (fd_cycle_log[0] !== retire_cycle_log[FRAME_BEATS / BURST_LEN - 1] + 1)
            $display("[TB] FAIL t3_fd_cycle: got %0d required %0d", fd_cycle_log[0], retire_cycle_log[FRAME_BEATS / BURST_LEN - 1] + 1); else n_pass++;
        n_checks++; if (data_mismatches() !== 0) $display("[TB] FAIL t3_wdata: got %0d bad beats required 0", data_mismatches()); else n_pass++;
    endtask

    task automatic test_frame_start_mid();
        bit to;
        do_reset();
        push_words(48);
        enable = 1'b1;
        wait_beats(BURST_LEN + 3, 400, to);
        fs_req = 1'b1;
        wait_retired(3, 600, to);
        n_checks++; if (to) $display("[TB] FAIL t4_timeout: got %0d retired required 3", retired); else n_pass++;
        n_checks++; if (aw_log[1] !== exp_addr(1)) $display("[TB] FAIL t4_awaddr1: got %h required %h", aw_log[1], exp_addr(1)); else n_pass++;
        n_checks++; if (aw_log[2] !== exp_addr(0)) $display("[TB] FAIL t4_awaddr2: got %h required %h", aw_log[2], exp_addr(0)); else n_pass++;
        n_checks++; if (beat_data_log.size() !== 48) $display("[TB] FAIL t4_beats: got %0d required 48", beat_data_log.size()); else n_pass++;
        n_checks++; if (fd_cycle_log.size() !== 0) $display("[TB] FAIL t4_frame_done: got %0d pulses required 0", fd_cycle_log.size()); else n_pass++;
    endtask

    task automatic test_enable_drop();
        bit to;
        do_reset();
        push_words(32);
        enable = 1'b1;
        wait_beats(4, 200, to);
        enable = 1'b0;
        repeat (60) step();
        n_checks++; if (aw_log.size() !== 1) $display("[TB] FAIL t5_bursts: got %0d required 1", aw_log.size()); else n_pass++;
        n_checks++; if (beat_data_log.size() !== 16) $display("[TB] FAIL t5_beats: got %0d required 16", beat_data_log.size()); else n_pass++;
        n_checks++; if (retired !== 1) $display("[TB] FAIL t5_retired: got %0d required 1", retired); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("[TB] FAIL t5_busy: got %b required 0", busy); else n_pass++;
    endtask

    task automatic test_stalls();
        bit to;
        do_reset();
        rand_ready = 1'b1;
        aw_hold = 7;
        bad_burst = 1;
        push_words(48);
        enable = 1'b1;
        wait_retired(3, 2000, to);
        repeat (4) step();
        n_checks++; if (to) $display("[TB] FAIL t6_timeout: got %0d retired required 3", retired); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (aw_log[k] !== exp_addr(k)) $display("[TB] FAIL t6_awaddr%0d: got %h required %h", k, aw_log[k], exp_addr(k)); else n_pass++;
        end
        n_checks++; if (aw_stall_total !== 21) $display("[TB] FAIL t6_aw_stall: got %0d cycles required 21", aw_stall_total); else n_pass++;
        n_checks++; if (beat_data_log.size() !== 48) $display("[TB] FAIL t6_beats: got %0d required 48", beat_data_log.size()); else n_pass++;
        n_checks++; if (data_mismatches() !== 0) $display("[TB] FAIL t6_wdata: got %0d bad beats required 0", data_mismatches()); else n_pass++;
        n_checks++; if (wlast_mismatches() !== 0) $display("[TB] FAIL t6_wlast: got %0d bad beats required 0", wlast_mismatches()); else n_pass++;
        n_checks++; if (viol !== 0) $display("[TB] FAIL t6_protocol: got %0d violations required 0", viol); else n_pass++;
        n_checks++; if (first_err_retired !== 2) $display("[TB] FAIL t6_err_rise: got %0d retired required 2", first_err_retired); else n_pass++;
        n_checks++; if (err !== 1'b1 || err_dropped) $display("[TB] FAIL t6_err_sticky: got err=%b dropped=%b required 1/0", err, err_dropped); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit to;
        do_reset();
        bad_burst = 0;
        push_words(48);
        enable = 1'b1;
        wait_beats(BURST_LEN + 8, 400, to);
        n_checks++; if (to || err !== 1'b1) $display("[TB] FAIL t7_pre_err: got err=%b timeout=%b required 1/0", err, to); else n_pass++;
        bad_burst = -1;
        rst_req = 1'b1;
        step();
        step();
        n_checks++; if ({m_awvalid, m_wvalid, m_wlast, m_bready, fifo_rd_en, busy, frame_done, err} !== 8'h00)
            $display("[TB] FAIL t7_reset_ctrl: got %b required 00000000", {m_awvalid, m_wvalid, m_wlast, m_bready, fifo_rd_en, busy, frame_done, err}); else n_pass++;
        n_checks++; if (m_awaddr !== BASE_ADDR) $display("[TB] FAIL t7_reset_awaddr: got %h required %h", m_awaddr, BASE_ADDR); else n_pass++;
        n_checks++; if (m_wdata !== '0) $display("[TB] FAIL t7_reset_wdata: got %h required 0", m_wdata); else n_pass++;
        clear_model();
        rst_req = 1'b0;
        wait_retired(1, 400, to);
        n_checks++; if (to) $display("[TB] FAIL t7_timeout: got %0d retired required 1", retired); else n_pass++;
        n_checks++; if (aw_log[0] !== BASE_ADDR) $display("[TB] FAIL t7_awaddr: got %h required %h", aw_log[0], BASE_ADDR); else n_pass++;
        n_checks++; if (data_mismatches() !== 0) $display("[TB] FAIL t7_wdata: got %0d bad beats required 0", data_mismatches()); else n_pass++;
        n_checks++; if (wlast_mismatches() !== 0) $display("[TB] FAIL t7_wlast: got %0d bad beats required 0", wlast_mismatches()); else n_pass++;
    endtask

    initial begin
        rst_req = 1'b1; fs_req = 1'b0; rand_ready = 1'b0; aw_hold = 0; bad_burst = -1; cycle = 0;
        clear_model();
        test_reset();
        test_two_bursts();
        test_fifo_gap();
        test_frame_wrap();
        test_frame_start_mid();
        test_enable_drop();
        test_stalls();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
